// File: rtl/ddram_wr_sched_if.sv
// Signal bundle between two frame-buffer writers, the write scheduler and the DDRAM write port.
// The master modport is the scheduler side; the slave modport is the writers and controller side.
interface ddram_wr_sched_if;
   logic        a_valid;
   logic        a_ready;
   logic [28:0] a_addr;
   logic [63:0] a_din;
   logic [7:0]  a_be;

   logic        b_valid;
   logic        b_ready;
   logic [28:0] b_addr;
   logic [63:0] b_din;
   logic [7:0]  b_be;

   logic        DDRAM_CLK;
   logic        DDRAM_BUSY;
   logic [7:0]  DDRAM_BURSTCNT;
   logic [28:0] DDRAM_ADDR;
   logic [63:0] DDRAM_DIN;
   logic [7:0]  DDRAM_BE;
   logic        DDRAM_WE;
   logic        DDRAM_RD;

   logic        grant_b;
   logic        idle;

   modport master (
      input  a_valid, a_addr, a_din, a_be,
      input  b_valid, b_addr, b_din, b_be,
      input  DDRAM_BUSY,
      output a_ready, b_ready,
      output DDRAM_CLK, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_RD,
      output grant_b, idle
   );

   modport slave (
      output a_valid, a_addr, a_din, a_be,
      output b_valid, b_addr, b_din, b_be,
      output DDRAM_BUSY,
      input  a_ready, b_ready,
      input  DDRAM_CLK, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_RD,
      input  grant_b, idle
   );
endinterface

// File: rtl/ddram_wr_sched.sv
// Two-requester write scheduler for the MiSTer DDRAM port: a registered FIFO per requester,
// round-robin or A-priority arbitration, and a held request register driving DDRAM_*.
module ddram_wr_sched #(
   parameter int unsigned FIFO_AW = 4,
   parameter bit          PRIO_A  = 1'b0
) (
   input logic              CLK_VIDEO,
   input logic              RESET_N,
   ddram_wr_sched_if.master bus
);

   localparam int unsigned      Entries = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] Depth   = {1'b1, {FIFO_AW{1'b0}}};

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StIssue = 1'b1;

   typedef struct packed {
      logic [28:0] addr;
      logic [63:0] din;
      logic [7:0]  be;
   } ent_t;

   // ---------------------------------------------------------------------------------------
   // Requester A FIFO
   // ---------------------------------------------------------------------------------------
   ent_t               mem_a [Entries];
   logic [FIFO_AW-1:0] wr_a_q, rd_a_q;
   logic [FIFO_AW:0]   cnt_a_q;
   logic               push_a, pop_a, a_ne;

   assign bus.a_ready = (cnt_a_q != Depth);
   assign push_a      = bus.a_valid & bus.a_ready;
   assign a_ne        = (cnt_a_q != '0);

   always_ff @(posedge CLK_VIDEO) begin
      if (push_a) begin
         mem_a[wr_a_q] <= '{addr: bus.a_addr, din: bus.a_din, be: bus.a_be};
      end
   end

   always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_a_q  <= '0;
         rd_a_q  <= '0;
         cnt_a_q <= '0;
      end else begin
         if (push_a) wr_a_q <= wr_a_q + 1'b1;
         if (pop_a)  rd_a_q <= rd_a_q + 1'b1;
         case ({push_a, pop_a})
            2'b10:   cnt_a_q <= cnt_a_q + 1'b1;
            2'b01:   cnt_a_q <= cnt_a_q - 1'b1;
            default: cnt_a_q <= cnt_a_q;
         endcase
      end
   end

   // ---------------------------------------------------------------------------------------
   // Requester B FIFO
   // ---------------------------------------------------------------------------------------
   ent_t               mem_b [Entries];
   logic [FIFO_AW-1:0] wr_b_q, rd_b_q;
   logic [FIFO_AW:0]   cnt_b_q;
   logic               push_b, pop_b, b_ne;

   assign bus.b_ready = (cnt_b_q != Depth);
   assign push_b      = bus.b_valid & bus.b_ready;
   assign b_ne        = (cnt_b_q != '0);

   always_ff @(posedge CLK_VIDEO) begin
      if (push_b) begin
         mem_b[wr_b_q] <= '{addr: bus.b_addr, din: bus.b_din, be: bus.b_be};
      end
   end

   always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_b_q  <= '0;
         rd_b_q  <= '0;
         cnt_b_q <= '0;
      end else begin
         if (push_b) wr_b_q <= wr_b_q + 1'b1;
         if (pop_b)  rd_b_q <= rd_b_q + 1'b1;
         case ({push_b, pop_b})
            2'b10:   cnt_b_q <= cnt_b_q + 1'b1;
            2'b01:   cnt_b_q <= cnt_b_q - 1'b1;
            default: cnt_b_q <= cnt_b_q;
         endcase
      end
   end

   // ---------------------------------------------------------------------------------------
   // Arbitration and issue
   // ---------------------------------------------------------------------------------------
   logic [0:0] state_q, state_d;
   logic       last_b_q;
   logic       gnt_q;
   ent_t       out_q;
   logic       sel_b;
   logic       load;
   ent_t       head;

   // Round-robin favours the port not served last; last_b resets to 1 so A wins the first tie.
   assign sel_b = PRIO_A ? (~a_ne & b_ne) : (b_ne & (~a_ne | ~last_b_q));
   assign head  = sel_b ? mem_b[rd_b_q] : mem_a[rd_a_q];
   assign pop_a = load & ~sel_b;
   assign pop_b = load & sel_b;

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         StIdle: begin
            if (a_ne | b_ne) begin
               load    = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            // The held request is taken this cycle; refill back-to-back if anything is queued.
            if (!bus.DDRAM_BUSY) begin
               if (a_ne | b_ne) begin
                  load = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= StIdle;
         last_b_q <= 1'b1;
         gnt_q    <= 1'b0;
         out_q    <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            out_q    <= head;
            gnt_q    <= sel_b;
            last_b_q <= sel_b;
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // DDRAM port
   // ---------------------------------------------------------------------------------------
   assign bus.DDRAM_CLK      = CLK_VIDEO;
   assign bus.DDRAM_BURSTCNT = 8'd1;
   assign bus.DDRAM_RD       = 1'b0;
   assign bus.DDRAM_ADDR     = out_q.addr;
   assign bus.DDRAM_DIN      = out_q.din;
   assign bus.DDRAM_BE       = out_q.be;
   assign bus.DDRAM_WE       = (state_q == StIssue);
   assign bus.grant_b        = gnt_q;
   assign bus.idle           = ~a_ne & ~b_ne & (state_q == StIdle);

endmodule

// File: tb/tb_ddram_wr_sched.sv
// Bench for ddram_wr_sched: one round-robin and one A-priority instance, directed scenarios plus
// random traffic checked against per-port queues of pushed-but-unwritten entries.
module tb_ddram_wr_sched;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ddram_wr_sched_if bus0 ();
   ddram_wr_sched_if bus1 ();

   ddram_wr_sched #(.FIFO_AW(4), .PRIO_A(1'b0)) u_rr (
      .CLK_VIDEO (clk),
      .RESET_N   (rst_n),
      .bus       (bus0)
   );

   ddram_wr_sched #(.FIFO_AW(4), .PRIO_A(1'b1)) u_pr (
      .CLK_VIDEO (clk),
      .RESET_N   (rst_n),
      .bus       (bus1)
   );

   typedef logic [100:0] ent_t;

   // Queue index = dut*2 + port; each holds entries pushed but not yet accepted by DDRAM.
   ent_t mq [4][$];
   logic glog0 [$];
   logic glog1 [$];
   int   n_acc [2];
   bit   pushed [4];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic accept(input int d, input logic gb, input ent_t got);
      int q;
      q = d * 2 + (gb ? 1 : 0);
      n_acc[d]++;
      if (d == 0) glog0.push_back(gb);
      else        glog1.push_back(gb);
      chk("accept_has_data", 128'(mq[q].size() != 0), 128'(1));
      if (mq[q].size() != 0) chk("accept_entry", 128'(got), 128'(mq[q].pop_front()));
   endtask

   // Observe the cycle about to be clocked, then advance to the next falling edge.
   task automatic tick();
      if (bus0.DDRAM_WE && !bus0.DDRAM_BUSY)
         accept(0, bus0.grant_b, {bus0.DDRAM_ADDR, bus0.DDRAM_DIN, bus0.DDRAM_BE});
      if (bus1.DDRAM_WE && !bus1.DDRAM_BUSY)
         accept(1, bus1.grant_b, {bus1.DDRAM_ADDR, bus1.DDRAM_DIN, bus1.DDRAM_BE});
      pushed[0] = bus0.a_valid && bus0.a_ready;
      pushed[1] = bus0.b_valid && bus0.b_ready;
      pushed[2] = bus1.a_valid && bus1.a_ready;
      pushed[3] = bus1.b_valid && bus1.b_ready;
      if (pushed[0]) mq[0].push_back({bus0.a_addr, bus0.a_din, bus0.a_be});
      if (pushed[1]) mq[1].push_back({bus0.b_addr, bus0.b_din, bus0.b_be});
      if (pushed[2]) mq[2].push_back({bus1.a_addr, bus1.a_din, bus1.a_be});
      if (pushed[3]) mq[3].push_back({bus1.b_addr, bus1.b_din, bus1.b_be});
      @(negedge clk);
   endtask

   task automatic quiet();
      bus0.a_valid = 1'b0; bus0.b_valid = 1'b0; bus0.DDRAM_BUSY = 1'b0;
      bus1.a_valid = 1'b0; bus1.b_valid = 1'b0; bus1.DDRAM_BUSY = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) mq[i].delete();
      glog0.delete();
      glog1.delete();
      rst_n = 1'b1;
   endtask

   task automatic drain();
      int guard;
      quiet();
      guard = 0;
      while (!(bus0.idle && bus1.idle) && guard < 200) begin
         tick();
         guard++;
      end
      chk("drain_idle", 128'(bus0.idle && bus1.idle), 128'(1));
      for (int i = 0; i < 4; i++) chk("drain_model_empty", 128'(mq[i].size()), 128'(0));
   endtask

   task automatic push_a0(input logic [28:0] addr, input logic [63:0] din, input logic [7:0] be);
      int guard;
      bus0.a_valid = 1'b1; bus0.a_addr = addr; bus0.a_din = din; bus0.a_be = be;
      guard = 0;
      do begin
         tick();
         guard++;
      end while (!pushed[0] && guard < 50);
      chk("push_a0_taken", 128'(pushed[0]), 128'(1));
      bus0.a_valid = 1'b0;
   endtask

   initial begin
      int         acc0, acc1, guard;
      logic [63:0] d3;
      ent_t        e18;

      bus0.a_addr = '0; bus0.a_din = '0; bus0.a_be = '0;
      bus0.b_addr = '0; bus0.b_din = '0; bus0.b_be = '0;
      bus1.a_addr = '0; bus1.a_din = '0; bus1.a_be = '0;
      bus1.b_addr = '0; bus1.b_din = '0; bus1.b_be = '0;
      quiet();
      n_acc[0] = 0; n_acc[1] = 0;
      @(negedge clk);
      do_reset();

      // Reset state
      chk("rst_we",       128'(bus0.DDRAM_WE), 128'(0));
      chk("rst_addr",     128'(bus0.DDRAM_ADDR), 128'(0));
      chk("rst_din",      128'(bus0.DDRAM_DIN), 128'(0));
      chk("rst_be",       128'(bus0.DDRAM_BE), 128'(0));
      chk("rst_grant",    128'(bus0.grant_b), 128'(0));
      chk("rst_a_ready",  128'(bus0.a_ready), 128'(1));
      chk("rst_b_ready",  128'(bus0.b_ready), 128'(1));
      chk("rst_idle",     128'(bus0.idle), 128'(1));
      chk("rst_burstcnt", 128'(bus0.DDRAM_BURSTCNT), 128'(1));
      chk("rst_rd",       128'(bus0.DDRAM_RD), 128'(0));
      chk("rst_ddram_clk", 128'(bus0.DDRAM_CLK), 128'(clk));

      // 1: three A writes, latency two cycles, back-to-back issue
      bus0.a_valid = 1'b1; bus0.a_be = 8'hff;
      bus0.a_addr = 29'h100; bus0.a_din = 64'hA0;
      chk("t1_we_s0", 128'(bus0.DDRAM_WE), 128'(0));
      tick();
      bus0.a_addr = 29'h101; bus0.a_din = 64'hA1;
      chk("t1_we_s1", 128'(bus0.DDRAM_WE), 128'(0));
      tick();
      bus0.a_addr = 29'h102; bus0.a_din = 64'hA2;
      chk("t1_we_s2", 128'(bus0.DDRAM_WE), 128'(1));
      chk("t1_addr_s2", 128'(bus0.DDRAM_ADDR), 128'(29'h100));
      chk("t1_grant_s2", 128'(bus0.grant_b), 128'(0));
      tick();
      bus0.a_valid = 1'b0;
      chk("t1_we_s3", 128'(bus0.DDRAM_WE), 128'(1));
      chk("t1_addr_s3", 128'(bus0.DDRAM_ADDR), 128'(29'h101));
      tick();
      chk("t1_we_s4", 128'(bus0.DDRAM_WE), 128'(1));
      chk("t1_addr_s4", 128'(bus0.DDRAM_ADDR), 128'(29'h102));
      tick();
      chk("t1_we_s5", 128'(bus0.DDRAM_WE), 128'(0));
      chk("t1_idle", 128'(bus0.idle), 128'(1));
      chk("t1_accepts", 128'(n_acc[0]), 128'(3));

      // 2: round-robin A,B,A,B,... with four entries on each port
      do_reset();
      acc0 = n_acc[0];
      for (int i = 0; i < 4; i++) begin
         bus0.a_valid = 1'b1; bus0.a_addr = 29'($urandom); bus0.a_din = {$urandom, $urandom};
         bus0.a_be = 8'($urandom);
         bus0.b_valid = 1'b1; bus0.b_addr = 29'($urandom); bus0.b_din = {$urandom, $urandom};
         bus0.b_be = 8'($urandom);
         tick();
      end
      drain();
      chk("t2_accepts", 128'(n_acc[0] - acc0), 128'(8));
      for (int i = 0; i < 8; i++)
         if (i < glog0.size()) chk("t2_grant_seq", 128'(glog0[i]), 128'(i % 2));

      // 3: request held stable for five busy cycles, then exactly one accept
      do_reset();
      bus0.DDRAM_BUSY = 1'b1;
      d3 = {$urandom, $urandom};
      push_a0(29'h1234, d3, 8'h5a);
      guard = 0;
      while (!bus0.DDRAM_WE && guard < 10) begin
         tick();
         guard++;
      end
      acc0 = n_acc[0];
      for (int i = 0; i < 5; i++) begin
         chk("t3_we_held", 128'(bus0.DDRAM_WE), 128'(1));
         chk("t3_addr_held", 128'(bus0.DDRAM_ADDR), 128'(29'h1234));
         chk("t3_din_held", 128'(bus0.DDRAM_DIN), 128'(d3));
         chk("t3_be_held", 128'(bus0.DDRAM_BE), 128'(8'h5a));
         tick();
      end
      chk("t3_no_accept_busy", 128'(n_acc[0] - acc0), 128'(0));
      bus0.DDRAM_BUSY = 1'b0;
      tick();
      chk("t3_one_accept", 128'(n_acc[0] - acc0), 128'(1));
      chk("t3_we_drop", 128'(bus0.DDRAM_WE), 128'(0));

      // 4: 17 entries fill output register plus FIFO; the 18th stalls but is not lost
      do_reset();
      bus0.DDRAM_BUSY = 1'b1;
      acc0 = n_acc[0];
      for (int i = 0; i < 17; i++) push_a0(29'(16'h4000 + i), {$urandom, $urandom}, 8'($urandom));
      e18 = {29'h4011, 64'hDEAD_BEEF_0000_0011, 8'h3c};
      bus0.a_valid = 1'b1;
      {bus0.a_addr, bus0.a_din, bus0.a_be} = e18;
      for (int i = 0; i < 3; i++) begin
         chk("t4_a_ready_full", 128'(bus0.a_ready), 128'(0));
         tick();
      end
      chk("t4_model_depth", 128'(mq[0].size()), 128'(17));
      bus0.DDRAM_BUSY = 1'b0;
      guard = 0;
      do begin
         tick();
         guard++;
      end while (!pushed[0] && guard < 20);
      chk("t4_stalled_push_taken", 128'(pushed[0]), 128'(1));
      drain();
      chk("t4_accepts", 128'(n_acc[0] - acc0), 128'(18));

      // 5: A priority keeps B waiting until A's FIFO empties
      do_reset();
      acc1 = n_acc[1];
      for (int i = 0; i < 10; i++) begin
         bus1.DDRAM_BUSY = (i < 4);
         bus1.a_valid = 1'b1; bus1.a_addr = 29'(i); bus1.a_din = {$urandom, $urandom};
         bus1.a_be = 8'hff;
         bus1.b_valid = (i < 2); bus1.b_addr = 29'(16'h8000 + i); bus1.b_din = {$urandom, $urandom};
         bus1.b_be = 8'h0f;
         tick();
      end
      drain();
      chk("t5_accepts", 128'(n_acc[1] - acc1), 128'(12));
      for (int i = 0; i < 12; i++)
         if (i < glog1.size()) chk("t5_grant_seq", 128'(glog1[i]), 128'(i >= 10));

      // Random traffic on both instances
      do_reset();
      for (int c = 0; c < 400; c++) begin
         bus0.a_valid = ($urandom_range(0, 2) != 0);
         bus0.b_valid = ($urandom_range(0, 2) != 0);
         bus1.a_valid = ($urandom_range(0, 2) != 0);
         bus1.b_valid = ($urandom_range(0, 2) != 0);
         bus0.DDRAM_BUSY = ($urandom_range(0, 9) < 4);
         bus1.DDRAM_BUSY = ($urandom_range(0, 9) < 2);
         bus0.a_addr = 29'($urandom); bus0.a_din = {$urandom, $urandom}; bus0.a_be = 8'($urandom);
         bus0.b_addr = 29'($urandom); bus0.b_din = {$urandom, $urandom}; bus0.b_be = 8'($urandom);
         bus1.a_addr = 29'($urandom); bus1.a_din = {$urandom, $urandom}; bus1.a_be = 8'($urandom);
         bus1.b_addr = 29'($urandom); bus1.b_din = {$urandom, $urandom}; bus1.b_be = 8'($urandom);
         tick();
      end
      drain();

      // 6: reset while a request is held with five more queued
      do_reset();
      bus0.DDRAM_BUSY = 1'b1;
      for (int i = 0; i < 6; i++) push_a0(29'(16'h6000 + i), {$urandom, $urandom}, 8'hff);
      tick();
      chk("t6_we_before", 128'(bus0.DDRAM_WE), 128'(1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_we_async_drop", 128'(bus0.DDRAM_WE), 128'(0));
      @(negedge clk);
      for (int i = 0; i < 4; i++) mq[i].delete();
      rst_n = 1'b1;
      bus0.DDRAM_BUSY = 1'b0;
      acc0 = n_acc[0];
      chk("t6_idle_after", 128'(bus0.idle), 128'(1));
      for (int i = 0; i < 20; i++) tick();
      chk("t6_no_writes", 128'(n_acc[0] - acc0), 128'(0));
      chk("t6_we_low", 128'(bus0.DDRAM_WE), 128'(0));
      chk("t6_idle_end", 128'(bus0.idle), 128'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
